fifo_serial_tx: RTL and testbench

- Consumer for the team's synchronous FIFO.
- Drains the FIFO by issuing pops and accounts for the FIFO's registered (1-cycle) read data.
- Serialises each word onto a single UART-style line: start bit, data LSB-first, optional even parity, stop bit(s).
- Sits between the FIFO's pop/data_out/empty interface and the chip-level tx pin.

---
 rtl/fifo_serial_tx_pkg.sv | 27 ++
 rtl/fifo_serial_tx_if.sv | 21 ++
 rtl/fifo_serial_tx_bit_timer.sv | 50 +++++
 rtl/fifo_serial_tx.sv | 146 ++++++++++++++
 tb/tb_fifo_serial_tx.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_serial_tx_pkg.sv
// ---------------------------------------------------------------------------
// fifo_tx_pkg
// Shared definitions for the FIFO-draining serial transmitter:
//   - default word width, bit period, stop-bit count and parity enable
//   - one-hot state encoding used by the transmitter FSM
// No ports (package).
// ---------------------------------------------------------------------------
package fifo_tx_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_STOP_BITS    = 1;
  localparam int DEF_PARITY_EN    = 0;

  // One-hot: each state is a single flop, so decoding any one state
  // (e.g. the pop strobe) is a plain register bit.
  typedef enum logic [6:0] {
    ST_IDLE   = 7'b000_0001,
    ST_POP    = 7'b000_0010,
    ST_LATCH  = 7'b000_0100,
    ST_START  = 7'b000_1000,
    ST_DATA   = 7'b001_0000,
    ST_PARITY = 7'b010_0000,
    ST_STOP   = 7'b100_0000
  } state_e;

endpackage

// File: rtl/fifo_serial_tx_if.sv
// ---------------------------------------------------------------------------
// fifo_serial_tx_if
// Read-side handshake between a synchronous FIFO and its consumer.
//   fifo_pop   : pop request, driven by the consumer (master)
//   fifo_empty : FIFO empty flag, driven by the FIFO (slave)
//   fifo_data  : FIFO read data, valid the cycle after a pop is sampled
// ---------------------------------------------------------------------------
interface fifo_serial_tx_if
  import fifo_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  fifo_pop;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;

  modport master (output fifo_pop, input fifo_empty, input fifo_data);
  modport slave  (input fifo_pop, output fifo_empty, output fifo_data);

endinterface

// File: rtl/fifo_serial_tx_bit_timer.sv
// ---------------------------------------------------------------------------
// fifo_tx_bit_timer
// Counts clk cycles within one serial bit period and strobes bit_end in the
// final cycle of that period. The counter is held at zero while run is low
// and restarts from zero after every bit_end.
// Ports:
//   clk, rst_n : clock, asynchronous active-high reset
//   run        : count while high, clear while low
//   stop_len   : 1 -> period is STOP_BITS*CLKS_PER_BIT, 0 -> CLKS_PER_BIT
//   bit_end    : high in the last cycle of the current period
// ---------------------------------------------------------------------------
module fifo_tx_bit_timer
  import fifo_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int STOP_BITS    = DEF_STOP_BITS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic stop_len,
  output logic bit_end
);

  // Sized for the longest period (two stop bits).
  localparam int CW = $clog2(2 * CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS * CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_end = run && (cnt_q == (stop_len ? LAST_STOP : LAST_BIT));
    cnt_d   = cnt_q;
    if (!run || bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// ---------------------------------------------------------------------------
// fifo_serial_tx
// Drains a synchronous FIFO one word at a time and sends each word on a
// UART-style line: start bit, data LSB-first, optional even parity, stop
// bit(s). Back-to-back frames are separated only by the POP and LATCH cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-high reset (despite the name)
//   enable     : permits new frames; only looked at in IDLE and at stop end
//   fifo       : master side of the FIFO read handshake (pop/empty/data)
//   tx         : serial line, idle high (registered)
//   busy       : high whenever the FSM is not in IDLE (registered)
//   frame_done : one-cycle pulse in the final stop-bit cycle
// ---------------------------------------------------------------------------
module fifo_serial_tx
  import fifo_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int STOP_BITS    = DEF_STOP_BITS,
  parameter int PARITY_EN    = DEF_PARITY_EN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  fifo_serial_tx_if.master        fifo,
  output logic                    tx,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  fifo_pop_q, fifo_pop_d;
  logic                  busy_q, busy_d;

  logic bit_end;
  logic timer_run;
  logic start_ok;

  assign timer_run = (state_q == ST_START) || (state_q == ST_DATA) ||
                     (state_q == ST_PARITY) || (state_q == ST_STOP);
  assign start_ok  = enable && !fifo.fifo_empty;

  fifo_tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .STOP_BITS    (STOP_BITS)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (timer_run),
    .stop_len (state_q == ST_STOP),
    .bit_end  (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_POP;
      end
      ST_POP: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        // FIFO read data is registered: it is valid now, one cycle after pop.
        shift_d  = fifo.fifo_data;
        parity_d = ^fifo.fifo_data;
        state_d  = ST_START;
      end
      ST_START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_IDX) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Chain straight into the next pop to keep the inter-frame gap at 2.
        if (bit_end) state_d = start_ok ? ST_POP : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state and registered, so each
    // output flop shows the value belonging to the state it will be in.
    fifo_pop_d = (state_d == ST_POP);
    busy_d     = (state_d != ST_IDLE);
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
      fifo_pop_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      fifo_pop_q <= fifo_pop_d;
      busy_q     <= busy_d;
    end
  end

  assign fifo.fifo_pop = fifo_pop_q;
  assign tx            = tx_q;
  assign busy          = busy_q;
  assign frame_done    = (state_q == ST_STOP) && bit_end;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_serial_tx
// Two transmitters (no parity / even parity, CLKS_PER_BIT=4, one stop bit),
// each fed by a small behavioural FIFO with registered read data. A frame
// model predicts tx/fifo_pop/busy/frame_done every cycle from the frame
// layout; directed tests add hand-computed literal checks.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_serial_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic en0 = 1'b0, en1 = 1'b0;
  logic tx0, tx1, busy0, busy1, fd0, fd1;

  fifo_serial_tx_if #(.DATA_WIDTH(DW)) if0 ();
  fifo_serial_tx_if #(.DATA_WIDTH(DW)) if1 ();

  fifo_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en0), .fifo(if0),
    .tx(tx0), .busy(busy0), .frame_done(fd0)
  );
  fifo_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en1), .fifo(if1),
    .tx(tx1), .busy(busy1), .frame_done(fd1)
  );

  // ---------------- behavioural FIFOs (registered read data) ----------------
  logic [7:0] fq0[$], fq1[$];
  logic [7:0] dout0 = 8'h00, dout1 = 8'h00;
  logic       empty0 = 1'b1, empty1 = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] val0 = 8'h00, val1 = 8'h00;

  always @(posedge clk) begin
    if (if0.fifo_pop && fq0.size() != 0) dout0 <= fq0.pop_front();
    if (req0) fq0.push_back(val0);
    empty0 <= (fq0.size() == 0);
  end
  always @(posedge clk) begin
    if (if1.fifo_pop && fq1.size() != 0) dout1 <= fq1.pop_front();
    if (req1) fq1.push_back(val1);
    empty1 <= (fq1.size() == 0);
  end

  assign if0.fifo_data  = dout0;
  assign if0.fifo_empty = empty0;
  assign if1.fifo_data  = dout1;
  assign if1.fifo_empty = empty1;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int pops[2];
  bit         m_active[2];
  int         m_k[2];
  logic [7:0] m_word[2];

  function automatic logic tx_of(input int ch);    return (ch == 0) ? tx0 : tx1; endfunction
  function automatic logic fd_of(input int ch);    return (ch == 0) ? fd0 : fd1; endfunction
  function automatic logic busy_of(input int ch);  return (ch == 0) ? busy0 : busy1; endfunction
  function automatic logic pop_of(input int ch);   return (ch == 0) ? if0.fifo_pop : if1.fifo_pop; endfunction
  function automatic logic en_of(input int ch);    return (ch == 0) ? en0 : en1; endfunction
  function automatic logic empty_of(input int ch); return (ch == 0) ? empty0 : empty1; endfunction
  function automatic logic [7:0] front_of(input int ch); return (ch == 0) ? fq0[0] : fq1[0]; endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic [7:0] w);
    if (ch == 0) begin req0 = 1'b1; val0 = w; end
    else         begin req1 = 1'b1; val1 = w; end
    cyc(1);
    req0 = 1'b0;
    req1 = 1'b0;
    $display("[TB] push ch%0d 0x%02h", ch, w);
  endtask

  // Frame model: k counts cycles from the POP cycle (k=0), LATCH (k=1), then
  // frame cycles k=2..L+1 laid out as CPB-cycle slots.
  task automatic compare_loop();
    logic e_tx, e_pop, e_busy, e_fd;
    int   len, slot;
    forever begin
      @(negedge clk);
      for (int ch = 0; ch < 2; ch++) begin
        len = (1 + DW + ch + 1) * CPB;
        if (rst_n) m_active[ch] = 1'b0;
        e_tx = 1'b1; e_pop = 1'b0; e_busy = 1'b0; e_fd = 1'b0;
        if (m_active[ch]) begin
          e_busy = 1'b1;
          e_pop  = (m_k[ch] == 0);
          e_fd   = (m_k[ch] == len + 1);
          if (m_k[ch] >= 2) begin
            slot = (m_k[ch] - 2) / CPB;
            if (slot == 0)                    e_tx = 1'b0;
            else if (slot <= DW)              e_tx = m_word[ch][slot-1];
            else if (ch == 1 && slot == DW+1) e_tx = ^m_word[ch];
          end
        end
        chk($sformatf("tx ch%0d", ch),         32'(tx_of(ch)),   32'(e_tx));
        chk($sformatf("fifo_pop ch%0d", ch),   32'(pop_of(ch)),  32'(e_pop));
        chk($sformatf("busy ch%0d", ch),       32'(busy_of(ch)), 32'(e_busy));
        chk($sformatf("frame_done ch%0d", ch), 32'(fd_of(ch)),   32'(e_fd));
        if (pop_of(ch)) pops[ch]++;
        if (!rst_n) begin
          if (!m_active[ch] || m_k[ch] == len + 1) begin
            if (en_of(ch) && !empty_of(ch)) begin
              m_active[ch] = 1'b1;
              m_k[ch]      = 0;
              m_word[ch]   = front_of(ch);
            end else begin
              m_active[ch] = 1'b0;
            end
          end else begin
            m_k[ch]++;
          end
        end
      end
    end
  endtask

  // Waits for a start bit, then samples the middle of each slot.
  task automatic capture(input int ch, input int nslots,
                         output logic [15:0] bits, output int fd_at, output int gap);
    int guard;
    bits = '0; fd_at = 0; gap = 0; guard = 0;
    @(negedge clk);
    while (tx_of(ch) !== 1'b0 && guard < 2000) begin
      gap++; guard++;
      @(negedge clk);
    end
    if (guard >= 2000) begin
      n_tests++; n_fail++;
      $display("FAIL start_timeout ch%0d: got no start bit, expected one within 2000 cycles", ch);
    end
    for (int c = 1; c <= nslots * CPB; c++) begin
      if (c > 1) @(negedge clk);
      if ((c - 1) % CPB == 1) bits[(c-1)/CPB] = tx_of(ch);
      if (fd_of(ch)) fd_at = c;
    end
    $display("[TB] frame ch%0d slots=0x%03h data=0x%02h frame_done@%0d gap=%0d",
             ch, bits[10:0], bits[8:1], fd_at, gap);
  endtask

  task automatic run_tests();
    logic [15:0] bits;
    int fd_at, gap, p0, bad, guard;

    // reset state
    #1 rst_n = 1'b1;
    #1;
    chk("reset tx", 32'(tx0), 32'd1);
    chk("reset fifo_pop", 32'(if0.fifo_pop), 32'd0);
    chk("reset busy", 32'(busy0), 32'd0);
    chk("reset frame_done", 32'(fd0), 32'd0);
    cyc(2);
    rst_n = 1'b0;
    cyc(2);

    // single word 0xA5
    p0 = pops[0];
    en0 = 1'b1;
    push(0, 8'hA5);
    capture(0, 10, bits, fd_at, gap);
    chk("A5 slots", 32'(bits[9:0]), 32'h34A);
    chk("A5 frame_done cycle", 32'(fd_at), 32'd40);
    @(negedge clk);
    chk("A5 busy after frame", 32'(busy0), 32'd0);
    chk("A5 pop count", 32'(pops[0] - p0), 32'd1);
    cyc(1);

    // parity words
    en1 = 1'b1;
    push(1, 8'h07);
    capture(1, 11, bits, fd_at, gap);
    chk("07 slots", 32'(bits[10:0]), 32'h60E);
    chk("07 parity slot", 32'(bits[9]), 32'd1);
    chk("07 frame_done cycle", 32'(fd_at), 32'd44);
    cyc(1);
    push(1, 8'h03);
    capture(1, 11, bits, fd_at, gap);
    chk("03 slots", 32'(bits[10:0]), 32'h406);
    chk("03 parity slot", 32'(bits[9]), 32'd0);
    cyc(2);
    en1 = 1'b0;

    // three words back to back
    en0 = 1'b0;
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
    p0 = pops[0];
    en0 = 1'b1;
    capture(0, 10, bits, fd_at, gap);
    chk("b2b word0", 32'(bits[8:1]), 32'h11);
    capture(0, 10, bits, fd_at, gap);
    chk("b2b word1", 32'(bits[8:1]), 32'h22);
    chk("b2b gap1", 32'(gap), 32'd2);
    capture(0, 10, bits, fd_at, gap);
    chk("b2b word2", 32'(bits[8:1]), 32'h33);
    chk("b2b gap2", 32'(gap), 32'd2);
    cyc(3);
    chk("b2b pop count", 32'(pops[0] - p0), 32'd3);
    chk("b2b fifo left", 32'(fq0.size()), 32'd0);

    // empty FIFO with enable held
    p0 = pops[0];
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
    end
    chk("empty pops", 32'(pops[0] - p0), 32'd0);
    chk("empty idle cycles", 32'(bad), 32'd0);
    cyc(1);

    // enable dropped mid-DATA
    en0 = 1'b0;
    push(0, 8'h5A); push(0, 8'hC3);
    p0 = pops[0];
    en0 = 1'b1;
    fork
      capture(0, 10, bits, fd_at, gap);
      begin cyc(14); en0 = 1'b0; end
    join
    chk("drop word", 32'(bits[8:1]), 32'h5A);
    cyc(20);
    chk("drop busy", 32'(busy0), 32'd0);
    chk("drop pop count", 32'(pops[0] - p0), 32'd1);
    chk("drop fifo left", 32'(fq0.size()), 32'd1);
    en0 = 1'b1;
    capture(0, 10, bits, fd_at, gap);
    chk("drain word", 32'(bits[8:1]), 32'hC3);
    cyc(3);

    // reset during DATA
    en0 = 1'b0;
    push(0, 8'hF0); push(0, 8'h0F);
    p0 = pops[0];
    en0 = 1'b1;
    guard = 0;
    @(negedge clk);
    while (tx0 !== 1'b0 && guard < 200) begin guard++; @(negedge clk); end
    chk("rst start seen", 32'(guard < 200), 32'd1);
    cyc(12);
    rst_n = 1'b1;
    #1;
    chk("rst tx", 32'(tx0), 32'd1);
    chk("rst fifo_pop", 32'(if0.fifo_pop), 32'd0);
    chk("rst busy", 32'(busy0), 32'd0);
    cyc(3);
    rst_n = 1'b0;
    capture(0, 10, bits, fd_at, gap);
    chk("rst next word", 32'(bits[8:1]), 32'h0F);
    cyc(3);
    chk("rst pop count", 32'(pops[0] - p0), 32'd2);
    chk("rst fifo left", 32'(fq0.size()), 32'd0);
    chk("rst busy end", 32'(busy0), 32'd0);
  endtask

  initial begin
    pops[0] = 0; pops[1] = 0;
    m_active[0] = 1'b0; m_active[1] = 1'b0;
    m_k[0] = 0; m_k[1] = 0;
    m_word[0] = 8'h00; m_word[1] = 8'h00;
    fork
      compare_loop();
      run_tests();
      begin
        #500000;
        n_tests++; n_fail++;
        $display("FAIL watchdog: got no completion, expected finish before 500 us");
      end
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
